// File: rtl/tile_frame_ctrl.sv
// Double-buffered board / next-tetromino store feeding the raster.
// Back buffer takes game writes; commits copy into the front buffer during vblank.
module tile_frame_ctrl #(
    parameter int         ROWS        = 20,
    parameter int         ROW_BITS    = 80,
    parameter int         NT_BITS     = 128,
    parameter logic [9:0] VBLANK_LINE = 10'd492
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [0:9]                 vcnt,
    input  logic                       wr_en,
    input  logic [0:4]                 wr_row,
    input  logic [0:ROW_BITS-1]        wr_data,
    input  logic                       nt_wr_en,
    input  logic [0:NT_BITS-1]         nt_data,
    output logic                       wr_ready,
    input  logic                       commit_req,
    output logic                       commit_ack,
    output logic                       busy,
    output logic [0:ROWS*ROW_BITS-1]   tiles,
    output logic [0:NT_BITS-1]         next_tets
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        COPY,
        DONE
    } state_t;

    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    state_t state;
    state_t state_nx;

    logic [4:0] row_cnt;
    logic [4:0] row_cnt_nx;

    logic vb_q;
    logic vb_now;
    logic vb_edge;
    logic row_ok;
    logic copy_last;

    logic [0:ROW_BITS-1] back_rows  [ROWS];
    logic [0:NT_BITS-1]  back_nt;
    logic [0:ROW_BITS-1] front_rows [ROWS];
    logic [0:NT_BITS-1]  front_nt;

    assign vb_now    = (vcnt == VBLANK_LINE);
    assign vb_edge   = vb_now & ~vb_q;
    assign row_ok    = (wr_row <= LAST_ROW);
    assign copy_last = (row_cnt == LAST_ROW);

    always_comb begin
        state_nx   = state;
        row_cnt_nx = row_cnt;
        wr_ready   = 1'b0;
        commit_ack = 1'b0;
        busy       = 1'b1;
        unique case (state)
            IDLE: begin
                wr_ready = 1'b1;
                busy     = 1'b0;
                if (commit_req) begin
                    state_nx = ARMED;
                end
            end
            ARMED: begin
                if (vb_edge) begin
                    state_nx   = COPY;
                    row_cnt_nx = '0;
                end
            end
            COPY: begin
                // Counter parks at zero after the last row instead of wrapping.
                if (copy_last) begin
                    state_nx   = DONE;
                    row_cnt_nx = '0;
                end else begin
                    row_cnt_nx = row_cnt + 5'd1;
                end
            end
            DONE: begin
                wr_ready   = 1'b1;
                commit_ack = 1'b1;
                state_nx   = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            row_cnt <= '0;
            vb_q    <= 1'b0;
        end else begin
            state   <= state_nx;
            row_cnt <= row_cnt_nx;
            vb_q    <= vb_now;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) begin
                back_rows[i] <= '0;
            end
            back_nt <= '0;
        end else begin
            if (wr_ready && wr_en && row_ok) begin
                back_rows[wr_row] <= wr_data;
            end
            if (wr_ready && nt_wr_en) begin
                back_nt <= nt_data;
            end
        end
    end

    // Front side only moves while copying, one row per clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) begin
                front_rows[i] <= '0;
            end
            front_nt <= '0;
        end else if (state == COPY) begin
            front_rows[row_cnt] <= back_rows[row_cnt];
            if (copy_last) begin
                front_nt <= back_nt;
            end
        end
    end

    for (genvar g = 0; g < ROWS; g++) begin : g_tiles
        assign tiles[g*ROW_BITS +: ROW_BITS] = front_rows[g];
    end

    assign next_tets = front_nt;

endmodule

// File: tb/tb_tile_frame_ctrl.sv
// Randomised scoreboard bench for tile_frame_ctrl.
// A cycle-level reference model predicts ack timing and front-buffer contents.
module tb_tile_frame_ctrl;

    localparam int ROWS = 20;
    localparam int RB   = 80;
    localparam int NB   = 128;
    localparam int TB   = ROWS * RB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [0:9]    vcnt = '0;
    logic          wr_en = 1'b0;
    logic [0:4]    wr_row = '0;
    logic [0:RB-1] wr_data = '0;
    logic          nt_wr_en = 1'b0;
    logic [0:NB-1] nt_data = '0;
    logic          wr_ready;
    logic          commit_req = 1'b0;
    logic          commit_ack;
    logic          busy;
    logic [0:TB-1] tiles;
    logic [0:NB-1] next_tets;

    tile_frame_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .vcnt       (vcnt),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_data    (wr_data),
        .nt_wr_en   (nt_wr_en),
        .nt_data    (nt_data),
        .wr_ready   (wr_ready),
        .commit_req (commit_req),
        .commit_ack (commit_ack),
        .busy       (busy),
        .tiles      (tiles),
        .next_tets  (next_tets)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [0:TB-1] tl;
        logic [0:NB-1] nt;
    } exp_t;

    exp_t sbq[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    bit            m_armed = 1'b0;
    int            m_ack_cyc = -1;
    logic [0:TB-1] back_m = '0;
    logic [0:TB-1] front_m = '0;
    logic [0:TB-1] snap_m = '0;
    logic [0:NB-1] back_nt_m = '0;
    logic [0:NB-1] front_nt_m = '0;
    logic [0:NB-1] snap_nt_m = '0;
    logic [9:0]    prev_vcnt = '0;
    bit            exp_busy = 1'b0;
    bit            exp_wr_ready = 1'b1;
    bit            exp_copying = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic cmp_front(input string nm, input logic [0:TB-1] et,
                             input logic [0:NB-1] en);
        int bad = -1;
        checks++;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (tiles[r*RB +: RB] !== et[r*RB +: RB]) bad = r;
        end
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s row%0d cycle %0d: got %h expected %h", nm, bad,
                     cyc, tiles[bad*RB +: RB], et[bad*RB +: RB]);
        end
        chk({nm, " next_tets"}, next_tets, en);
    endtask

    // Commit accepted in idle waits for the next fresh vblank line; the front
    // buffer then equals the back buffer snapshot, 21 cycles after that edge.
    function automatic void model_eval();
        bit edge_now;
        edge_now = (vcnt == 10'd492) && (prev_vcnt != 10'd492);
        exp_busy = m_armed || (m_ack_cyc >= 0 && cyc <= m_ack_cyc);
        exp_wr_ready = !m_armed && !(m_ack_cyc >= 0 && cyc < m_ack_cyc);
        exp_copying = (m_ack_cyc >= 0 && cyc < m_ack_cyc);
        if (m_ack_cyc == cyc) begin
            front_m = snap_m;
            front_nt_m = snap_nt_m;
        end
        if (rst) begin
            m_armed = 1'b0;
            m_ack_cyc = -1;
            back_m = '0;
            back_nt_m = '0;
            front_m = '0;
            front_nt_m = '0;
            prev_vcnt = '0;
            sbq.delete();
            return;
        end
        if (m_armed && edge_now) begin
            snap_m = back_m;
            snap_nt_m = back_nt_m;
            m_ack_cyc = cyc + 21;
            m_armed = 1'b0;
            sbq.push_back('{m_ack_cyc, back_m, back_nt_m});
        end else if (!exp_busy && commit_req) begin
            m_armed = 1'b1;
        end
        if (exp_wr_ready) begin
            if (wr_en && int'(wr_row) < ROWS) back_m[int'(wr_row)*RB +: RB] = wr_data;
            if (nt_wr_en) back_nt_m = nt_data;
        end
        prev_vcnt = vcnt;
    endfunction

    task automatic step();
        model_eval();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    always @(negedge clk) begin
        bit   exp_ack;
        exp_t e;
        if (mon_en && !rst) begin
            exp_ack = (sbq.size() > 0 && sbq[0].cyc == cyc);
            chk("wr_ready", wr_ready, exp_wr_ready);
            chk("busy", busy, exp_busy);
            chk("commit_ack", commit_ack, exp_ack);
            if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                e = sbq.pop_front();
                if (commit_ack) cmp_front("ack contents", e.tl, e.nt);
            end
            if (!exp_copying) cmp_front("front hold", front_m, front_nt_m);
        end
    end

    task automatic quiet();
        wr_en = 1'b0;
        nt_wr_en = 1'b0;
        commit_req = 1'b0;
    endtask

    task automatic do_reset(input int n);
        quiet();
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic vblank(input int hold);
        vcnt = 10'd491;
        step();
        vcnt = 10'd492;
        repeat (hold) step();
        vcnt = 10'd493;
        step();
    endtask

    task automatic commit();
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
    endtask

    task automatic write_row(input int r, input logic [0:RB-1] d);
        wr_en = 1'b1;
        wr_row = 5'(r);
        wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    function automatic logic [0:RB-1] rnd_row();
        logic [95:0] r96;
        r96 = {$urandom(), $urandom(), $urandom()};
        return r96[79:0];
    endfunction

    initial begin
        logic [7:0]    b;
        logic [0:RB-1] row;
        int            v;

        do_reset(2);
        chk("reset tiles hi", tiles[0:127], '0);
        chk("reset next_tets", next_tets, '0);
        chk("reset wr_ready", wr_ready, 1'b1);
        chk("reset busy", busy, 1'b0);

        vcnt = 10'd100;
        for (int r = 0; r < ROWS; r++) begin
            b = 8'(r);
            write_row(r, {10{b}});
        end
        nt_wr_en = 1'b1;
        nt_data = {16{8'hA5}};
        step();
        nt_wr_en = 1'b0;
        commit();
        repeat (5) step();
        vblank(30);
        repeat (3) step();
        row = {10{8'h07}};
        chk("basic row7", tiles[7*RB +: RB], row);

        commit();
        write_row(5, '1);
        vblank(30);
        row = {10{8'h05}};
        chk("lock row5", tiles[5*RB +: RB], row);

        vcnt = 10'd0;
        write_row(3, rnd_row());
        vcnt = 10'd491;
        step();
        vcnt = 10'd492;
        commit();
        repeat (30) step();
        vcnt = 10'd0;
        repeat (3) step();
        vblank(30);
        repeat (3) step();

        vcnt = 10'd10;
        write_row(20, rnd_row());
        write_row(31, rnd_row());
        write_row(9, rnd_row());
        commit();
        vcnt = 10'd491;
        step();
        vcnt = 10'd492;
        step();
        commit_req = 1'b1;
        repeat (10) step();
        commit_req = 1'b0;
        repeat (30) step();
        vcnt = 10'd0;
        repeat (3) step();

        for (int r = 0; r < ROWS; r += 3) write_row(r, rnd_row());
        commit();
        vcnt = 10'd491;
        step();
        vcnt = 10'd492;
        step();
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vcnt = 10'd0;
        repeat (30) step();
        chk("midcopy reset busy", busy, 1'b0);
        write_row(2, rnd_row());
        commit();
        vblank(30);
        repeat (3) step();

        v = 0;
        repeat (3000) begin
            wr_en = ($urandom_range(0, 3) == 0);
            wr_row = 5'($urandom_range(0, 31));
            wr_data = rnd_row();
            nt_wr_en = ($urandom_range(0, 7) == 0);
            nt_data = {rnd_row(), 48'($urandom())};
            commit_req = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 999) == 0);
            v = ($urandom_range(0, 49) == 0) ? 488 : (v + 1) % 525;
            vcnt = 10'(v);
            step();
        end
        quiet();
        rst = 1'b0;
        vcnt = 10'd0;
        repeat (60) step();
        chk("pending acks", 128'(sbq.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
